// File: rtl/sound_event_sequencer_if.sv
// Request/configuration inputs and tone-generator outputs of the sound event sequencer.
interface sound_event_sequencer_if #(
  parameter int NUM_EVENTS = 4,
  parameter int FREQ_W     = 4,
  parameter int DUR_W      = 4
);
  localparam int ID_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  logic [NUM_EVENTS-1:0]        event_pulse;
  logic [NUM_EVENTS*FREQ_W-1:0] cfg_freq_a;
  logic [NUM_EVENTS*FREQ_W-1:0] cfg_freq_b;
  logic [NUM_EVENTS*DUR_W-1:0]  cfg_dur;
  logic                         enable_sound;
  logic [FREQ_W-1:0]            freq;
  logic                         busy;
  logic [ID_W-1:0]              active_id;

  modport master (
    output event_pulse, cfg_freq_a, cfg_freq_b, cfg_dur,
    input  enable_sound, freq, busy, active_id
  );

  modport slave (
    input  event_pulse, cfg_freq_a, cfg_freq_b, cfg_dur,
    output enable_sound, freq, busy, active_id
  );
endinterface

// File: rtl/sound_event_sequencer.sv
// Prioritised one- or two-note sound event player driving a tone generator.
// Lower channel index wins; equal index retriggers; higher index is dropped while busy.
module sound_event_sequencer #(
  parameter int NUM_EVENTS = 4,
  parameter int FREQ_W     = 4,
  parameter int DUR_W      = 4,
  parameter int TICK_DIV   = 5_000_000
) (
  input logic                  clk,
  input logic                  resetN,
  sound_event_sequencer_if.slave bus
);
  localparam int ID_W   = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, NOTE_A = 2'd1, NOTE_B = 2'd2} state_t;

  state_t            state, stateNext;
  logic [TICK_W-1:0] tickCnt, tickNext;
  logic [DUR_W-1:0]  noteCnt, noteNext;
  logic [DUR_W-1:0]  durLat, durNext;
  logic [FREQ_W-1:0] freqBLat, freqBNext;
  logic [FREQ_W-1:0] freqReg, freqNext;
  logic [ID_W-1:0]   activeId, idNext;
  logic              enableReg, enableNext;

  logic              winValid;
  logic [ID_W-1:0]   winIdx;
  logic [FREQ_W-1:0] winFreqA, winFreqB;
  logic [DUR_W-1:0]  winDur;
  logic              accept, noteDone;

  // Fixed-priority arbiter: lowest asserted channel and its configuration.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    winFreqA = '0;
    winFreqB = '0;
    winDur   = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (bus.event_pulse[i] && !winValid) begin
        winValid = 1'b1;
        winIdx   = ID_W'(i);
        winFreqA = bus.cfg_freq_a[i*FREQ_W +: FREQ_W];
        winFreqB = bus.cfg_freq_b[i*FREQ_W +: FREQ_W];
        winDur   = bus.cfg_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  assign accept   = winValid && ((state == IDLE) || (winIdx <= activeId));
  assign noteDone = (tickCnt == TICK_LAST) && (noteCnt == durLat - DUR_W'(1));

  // Next-state, counters and registered-output values; a start/preempt overrides expiry.
  always_comb begin
    stateNext = state;
    tickNext  = tickCnt;
    noteNext  = noteCnt;
    durNext   = durLat;
    freqBNext = freqBLat;
    freqNext  = freqReg;
    idNext    = activeId;
    if (accept) begin
      stateNext = NOTE_A;
      tickNext  = '0;
      noteNext  = '0;
      idNext    = winIdx;
      freqNext  = winFreqA;
      freqBNext = winFreqB;
      durNext   = (winDur == '0) ? DUR_W'(1) : winDur;
    end else if (state != IDLE) begin
      if (noteDone) begin
        tickNext = '0;
        noteNext = '0;
        if ((state == NOTE_A) && (freqBLat != '0)) begin
          stateNext = NOTE_B;
          freqNext  = freqBLat;
        end else begin
          stateNext = IDLE;
        end
      end else if (tickCnt == TICK_LAST) begin
        tickNext = '0;
        noteNext = noteCnt + DUR_W'(1);
      end else begin
        tickNext = tickCnt + TICK_W'(1);
      end
    end
    enableNext = (stateNext != IDLE);
  end

  // State, counters, latched configuration and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      tickCnt   <= '0;
      noteCnt   <= '0;
      durLat    <= '0;
      freqBLat  <= '0;
      freqReg   <= '0;
      activeId  <= '0;
      enableReg <= 1'b0;
    end else begin
      state     <= stateNext;
      tickCnt   <= tickNext;
      noteCnt   <= noteNext;
      durLat    <= durNext;
      freqBLat  <= freqBNext;
      freqReg   <= freqNext;
      activeId  <= idNext;
      enableReg <= enableNext;
    end
  end

  assign bus.enable_sound = enableReg;
  assign bus.freq         = freqReg;
  assign bus.busy         = (state != IDLE);
  assign bus.active_id    = activeId;
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: directed scenario table, hand-written corner
// sequences and randomized traffic against a cycle-countdown reference model.
module tb_sound_event_sequencer;
  localparam int NE = 4;
  localparam int FW = 4;
  localparam int DW = 4;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  sound_event_sequencer_if #(.NUM_EVENTS(NE), .FREQ_W(FW), .DUR_W(DW)) bus ();

  sound_event_sequencer #(
    .NUM_EVENTS(NE), .FREQ_W(FW), .DUR_W(DW), .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: playing flag, channel, note phase and cycles left in the note.
  bit mPlay   = 0;
  int mId     = 0;
  bit mNoteB  = 0;
  int mRemain = 0;
  int mFreq   = 0;
  int mFb     = 0;
  int mDurCyc = 0;

  typedef struct {
    int ch; int fa; int fb; int dur; int expA; int expB;
  } scen_t;
  scen_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int cfgA(input int k);
    return int'(bus.cfg_freq_a[k*FW +: FW]);
  endfunction
  function automatic int cfgB(input int k);
    return int'(bus.cfg_freq_b[k*FW +: FW]);
  endfunction
  function automatic int cfgD(input int k);
    return int'(bus.cfg_dur[k*DW +: DW]);
  endfunction

  task automatic modelStep();
    int win;
    win = -1;
    if (!resetN) begin
      mPlay = 0; mId = 0; mFreq = 0; mNoteB = 0; mRemain = 0; mFb = 0; mDurCyc = 0;
      return;
    end
    for (int i = 0; i < NE; i++)
      if (bus.event_pulse[i] && win < 0) win = i;
    if (win >= 0 && (!mPlay || win <= mId)) begin
      mPlay   = 1;
      mId     = win;
      mNoteB  = 0;
      mDurCyc = ((cfgD(win) == 0) ? 1 : cfgD(win)) * TD;
      mRemain = mDurCyc;
      mFreq   = cfgA(win);
      mFb     = cfgB(win);
    end else if (mPlay) begin
      mRemain--;
      if (mRemain == 0) begin
        if (!mNoteB && mFb != 0) begin
          mNoteB  = 1;
          mFreq   = mFb;
          mRemain = mDurCyc;
        end else begin
          mPlay = 0;
        end
      end
    end
  endtask

  task automatic compareModel();
    check("model_enable", int'(bus.enable_sound), int'(mPlay));
    check("model_busy", int'(bus.busy), int'(mPlay));
    check("model_freq", int'(bus.freq), mFreq);
    if (mPlay) check("model_active_id", int'(bus.active_id), mId);
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic pulse(input logic [NE-1:0] mask);
    bus.event_pulse = mask;
    cycle();
    bus.event_pulse = '0;
  endtask

  task automatic setCfg(input int ch, input int a, input int b, input int d);
    bus.cfg_freq_a[ch*FW +: FW] = FW'(a);
    bus.cfg_freq_b[ch*FW +: FW] = FW'(b);
    bus.cfg_dur[ch*DW +: DW]    = DW'(d);
  endtask

  initial begin
    int na, nb, holdF;
    bus.event_pulse = '0;
    bus.cfg_freq_a  = '0;
    bus.cfg_freq_b  = '0;
    bus.cfg_dur     = '0;

    // Reset state
    repeat (3) cycle();
    resetN = 1'b1;
    check("reset_enable", int'(bus.enable_sound), 0);
    check("reset_freq", int'(bus.freq), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_active_id", int'(bus.active_id), 0);
    cycle();

    // Scenario table: note lengths in cycles, then idle with held frequency
    tbl[0] = '{ch: 3, fa: 5,  fb: 0,  dur: 2,  expA: 8,  expB: 0};
    tbl[1] = '{ch: 0, fa: 1,  fb: 2,  dur: 3,  expA: 12, expB: 12};
    tbl[2] = '{ch: 2, fa: 9,  fb: 0,  dur: 0,  expA: 4,  expB: 0};
    tbl[3] = '{ch: 1, fa: 6,  fb: 3,  dur: 1,  expA: 4,  expB: 4};
    tbl[4] = '{ch: 0, fa: 15, fb: 14, dur: 15, expA: 60, expB: 60};
    for (int t = 0; t < 5; t++) begin
      setCfg(tbl[t].ch, tbl[t].fa, tbl[t].fb, tbl[t].dur);
      pulse(NE'(1 << tbl[t].ch));
      check("tbl_start_id", int'(bus.active_id), tbl[t].ch);
      na = 0;
      while (bus.enable_sound && int'(bus.freq) == tbl[t].fa && na < 200) begin
        na++;
        cycle();
      end
      nb = 0;
      while (tbl[t].fb != 0 && bus.enable_sound && int'(bus.freq) == tbl[t].fb && nb < 200) begin
        nb++;
        cycle();
      end
      holdF = (tbl[t].fb != 0) ? tbl[t].fb : tbl[t].fa;
      check("tbl_note_a_cycles", na, tbl[t].expA);
      check("tbl_note_b_cycles", nb, tbl[t].expB);
      check("tbl_end_enable", int'(bus.enable_sound), 0);
      check("tbl_end_busy", int'(bus.busy), 0);
      check("tbl_end_freq_hold", int'(bus.freq), holdF);
      cycle();
    end

    // Preempt by a higher-priority channel, then a lower-priority pulse is ignored
    setCfg(3, 5, 0, 2);
    setCfg(1, 7, 0, 1);
    setCfg(2, 9, 0, 1);
    pulse(4'b1000);
    cycle();
    cycle();
    pulse(4'b0010);
    check("preempt_freq", int'(bus.freq), 7);
    check("preempt_id", int'(bus.active_id), 1);
    cycle();
    pulse(4'b0100);
    check("ignore_freq", int'(bus.freq), 7);
    check("ignore_id", int'(bus.active_id), 1);
    cycle();
    check("preempt_last_cycle", int'(bus.enable_sound), 1);
    cycle();
    check("preempt_end_enable", int'(bus.enable_sound), 0);
    check("preempt_end_busy", int'(bus.busy), 0);
    repeat (2) cycle();

    // Simultaneous pulses, then retrigger mid-note restarts the full duration
    setCfg(1, 6, 0, 2);
    pulse(4'b0110);
    check("simul_id", int'(bus.active_id), 1);
    check("simul_freq", int'(bus.freq), 6);
    repeat (5) cycle();
    pulse(4'b0010);
    repeat (7) cycle();
    check("retrig_still_on", int'(bus.enable_sound), 1);
    cycle();
    check("retrig_end", int'(bus.enable_sound), 0);
    repeat (2) cycle();

    // Configuration changed mid-event does not affect the playing event
    setCfg(2, 3, 4, 1);
    pulse(4'b0100);
    cycle();
    setCfg(2, 9, 0, 5);
    repeat (2) cycle();
    check("cfglatch_a", int'(bus.freq), 3);
    cycle();
    check("cfglatch_b", int'(bus.freq), 4);
    repeat (3) cycle();
    check("cfglatch_b_last", int'(bus.enable_sound), 1);
    cycle();
    check("cfglatch_end", int'(bus.enable_sound), 0);
    repeat (2) cycle();

    // Lower-priority pulse on the expiry edge is dropped, accepted if still held
    setCfg(1, 6, 0, 1);
    setCfg(3, 5, 0, 1);
    pulse(4'b0010);
    repeat (3) cycle();
    bus.event_pulse = 4'b1000;
    cycle();
    check("expiry_edge_idle", int'(bus.busy), 0);
    cycle();
    bus.event_pulse = '0;
    check("expiry_held_accept", int'(bus.freq), 5);
    check("expiry_held_id", int'(bus.active_id), 3);
    repeat (6) cycle();

    // Asynchronous reset in the middle of the second note
    setCfg(0, 1, 2, 1);
    pulse(4'b0001);
    repeat (5) cycle();
    check("pre_reset_note_b", int'(bus.freq), 2);
    resetN = 1'b0;
    #1;
    modelStep();
    check("async_reset_enable", int'(bus.enable_sound), 0);
    check("async_reset_freq", int'(bus.freq), 0);
    check("async_reset_busy", int'(bus.busy), 0);
    cycle();
    resetN = 1'b1;
    repeat (4) cycle();
    check("post_reset_silent", int'(bus.enable_sound), 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < NE; k++)
          setCfg(k, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
                 int'($urandom_range(0, 3)));
      end
      bus.event_pulse = ($urandom_range(0, 5) == 0) ? NE'($urandom_range(1, 15)) : '0;
      if ($urandom_range(0, 499) == 0) resetN = 1'b0;
      cycle();
      resetN = 1'b1;
    end
    bus.event_pulse = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sound_event_sequencer.md
SOUND_EVENT_SEQUENCER -- requirements
Module: sound_event_sequencer

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 4: number of prioritised sound-event channels; index 0 is highest priority.
REQ-002 SHALL have parameter FREQ_W, default 4: width of the tone-index output and of each configured frequency.
REQ-003 SHALL have parameter DUR_W, default 4: width of each per-note duration, in ticks.
REQ-004 SHALL have parameter TICK_DIV, default 5_000_000: clk cycles per tick (0.1 s at 50 MHz).
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 resetN  input  1  asynchronous, active-low reset.
REQ-007 event_pulse  input  NUM_EVENTS  one-cycle request per channel (win, lose, scored, collision, ...).
REQ-008 cfg_freq_a  input  NUM_EVENTS*FREQ_W  first-note tone index per channel; channel k at bits [k*FREQ_W +: FREQ_W].
REQ-009 cfg_freq_b  input  NUM_EVENTS*FREQ_W  second-note tone index per channel; 0 = single-note event.
REQ-010 cfg_dur  input  NUM_EVENTS*DUR_W  duration of each note per channel, in ticks.
REQ-011 enable_sound  output  1  tone generator enable, registered.
REQ-012 freq  output  FREQ_W  tone index to tone generator, registered.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 active_id  output  $clog2(NUM_EVENTS) (min 1)  channel currently playing; valid when busy.

Function
REQ-015 SHALL implement states IDLE, NOTE_A, NOTE_B.
REQ-016 SHALL arbitrate simultaneous pulses by fixed priority: the lowest asserted index wins, others in that cycle are dropped.
REQ-017 In IDLE, a winning pulse at cycle N SHALL give NOTE_A, enable_sound=1, freq=cfg_freq_a[win], active_id=win at cycle N+1.
REQ-018 Configuration SHALL be latched at event start; cfg changes mid-event SHALL not affect the playing event.
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 and restart at 0 on every event start, preemption and note change.
REQ-020 Note counter SHALL count ticks; a note SHALL last exactly max(cfg_dur,1) ticks (cfg_dur=0 treated as 1).
REQ-021 At NOTE_A expiry with latched freq_b != 0: next cycle NOTE_B, freq=freq_b, enable_sound stays 1, no gap cycle.
REQ-022 At NOTE_A expiry with freq_b == 0, or at NOTE_B expiry: next cycle IDLE, enable_sound=0, freq holds last value.
REQ-023 While busy, a pulse with index < active_id SHALL preempt: restart NOTE_A with the new channel, next cycle.
REQ-024 While busy, a pulse with index == active_id SHALL retrigger: restart NOTE_A of that channel, counters cleared.
REQ-025 While busy, pulses with index > active_id SHALL be ignored, not queued.
REQ-026 A preempting/retrigger pulse in the same cycle as note expiry SHALL take precedence over the expiry transition.
REQ-027 A pulse arriving in the same cycle the machine returns to IDLE SHALL be accepted as in REQ-017 one cycle later only if still asserted; single-cycle pulses at the expiry edge are evaluated against the pre-expiry active_id.
REQ-028 enable_sound SHALL be 1 exactly in NOTE_A and NOTE_B.

Reset
REQ-029 On resetN low, asynchronously: state=IDLE, enable_sound=0, freq=0, busy=0, active_id=0, all counters and latched config 0.
REQ-030 Reset mid-event SHALL abort the event; after release, no sound until a new pulse.

Verification (NUM_EVENTS=4, TICK_DIV=4, DUR_W=4)
REQ-031 Single note: ch3 freq_a=5, freq_b=0, dur=2; pulse ch3 -> enable_sound=1, freq=5 for exactly 8 cycles, then 0, busy 0.
REQ-032 Two notes: ch0 freq_a=1, freq_b=2, dur=3 -> freq=1 for 12 cycles, freq=2 for 12 cycles, enable continuous, then idle.
REQ-033 Preempt/ignore: ch3 playing, pulse ch1 (freq_a=7) at cycle 3 -> freq=7 next cycle, new full duration; later ch2 pulse ignored.
REQ-034 Simultaneous: pulses ch2 and ch1 same cycle -> active_id=1; retrigger ch1 mid-note restarts full duration.
REQ-035 Edge cases: dur=0 -> 4-cycle note; resetN low mid-NOTE_B -> enable_sound=0, freq=0 immediately, idle after release.
